// File: rtl/mux_sel_seq_if.sv
// Bus bundle between a controller and the mux select-pattern sequencer.
// The controller drives the run request and pattern; the sequencer returns
// the registered select line together with its progress and status flags.
interface mux_sel_seq_if #(
  parameter int LEN = 5,
  parameter int SW  = 3,
  parameter int RW  = 2
);
  logic           start;
  logic           abort;
  logic [LEN-1:0] pattern_in;
  logic           s;
  logic           busy;
  logic           step_strobe;
  logic [SW-1:0]  step_idx;
  logic [RW-1:0]  rep_idx;
  logic           done;

  modport master (
    output start, abort, pattern_in,
    input  s, busy, step_strobe, step_idx, rep_idx, done
  );

  modport slave (
    input  start, abort, pattern_in,
    output s, busy, step_strobe, step_idx, rep_idx, done
  );
endinterface

// File: rtl/mux_sel_seq.sv
// Select-pattern sequencer feeding the select input of a 2:1 mux.
// A captured LEN-bit pattern is played LSB first, with each bit held for HOLD
// cycles and the whole pattern repeated REPEAT times. Every output comes
// straight from a flop, so nothing on the bus is combinational from an input.
module mux_sel_seq #(
  parameter int LEN    = 5,
  parameter int HOLD   = 10,
  parameter int REPEAT = 3,
  parameter int SW     = (LEN > 1) ? $clog2(LEN) : 1,
  parameter int RW     = (REPEAT > 1) ? $clog2(REPEAT) : 1
) (
  input logic          clk,
  input logic          rst,
  mux_sel_seq_if.slave bus
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  // Terminal values; equality against these avoids constant-false compares
  // when LEN, HOLD or REPEAT is 1.
  localparam logic [SW-1:0] LAST_STEP = SW'(LEN - 1);
  localparam logic [RW-1:0] LAST_REP  = RW'(REPEAT - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [LEN-1:0] pat_reg, pat_nxt;
  logic [HW-1:0]  cnt, cnt_nxt;
  logic [SW-1:0]  step, step_nxt;
  logic [RW-1:0]  rep, rep_nxt;
  logic           s_reg, s_nxt;
  logic           busy_reg, busy_nxt;
  logic           strobe_reg, strobe_nxt;
  logic           done_reg, done_nxt;

  // State and output registers; reset dominates abort and start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pat_reg    <= '0;
      cnt        <= '0;
      step       <= '0;
      rep        <= '0;
      s_reg      <= 1'b0;
      busy_reg   <= 1'b0;
      strobe_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pat_reg    <= pat_nxt;
      cnt        <= cnt_nxt;
      step       <= step_nxt;
      rep        <= rep_nxt;
      s_reg      <= s_nxt;
      busy_reg   <= busy_nxt;
      strobe_reg <= strobe_nxt;
      done_reg   <= done_nxt;
    end
  end

  // Next-state logic; the select for the coming cycle is looked up from the
  // next pattern and step so that s always matches pattern_reg[step_idx].
  always_comb begin
    state_nxt  = state;
    pat_nxt    = pat_reg;
    cnt_nxt    = cnt;
    step_nxt   = step;
    rep_nxt    = rep;
    strobe_nxt = 1'b0;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt  = RUN;
          pat_nxt    = bus.pattern_in;
          cnt_nxt    = '0;
          step_nxt   = '0;
          rep_nxt    = '0;
          strobe_nxt = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          step_nxt  = '0;
          rep_nxt   = '0;
        end else if (cnt == LAST_HOLD) begin
          cnt_nxt = '0;
          if (step != LAST_STEP) begin
            step_nxt   = step + 1'b1;
            strobe_nxt = 1'b1;
          end else if (rep != LAST_REP) begin
            step_nxt   = '0;
            rep_nxt    = rep + 1'b1;
            strobe_nxt = 1'b1;
          end else begin
            state_nxt = DONE;
            step_nxt  = '0;
            rep_nxt   = '0;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == RUN);
    s_nxt    = busy_nxt ? pat_nxt[step_nxt] : 1'b0;
  end

  assign bus.s           = s_reg;
  assign bus.busy        = busy_reg;
  assign bus.step_strobe = strobe_reg;
  assign bus.step_idx    = step;
  assign bus.rep_idx     = rep;
  assign bus.done        = done_reg;

endmodule

// File: doc/mux_sel_seq.md
Name: mux_sel_seq

Overview:
- Select-pattern sequencer that sits directly upstream of the 2:1 mux and drives its select line `s`.
- Plays a programmable LEN-bit select pattern, LSB first.
- Each pattern bit is held for HOLD clock cycles, and the full pattern repeats REPEAT times.
- Signals busy while running and pulses done at the end, so a bench or controller can sample the mux output once per step.

Parameters:
- LEN, 5, number of steps in the select pattern (>=1).
- HOLD, 10, clock cycles each step is held (>=1).
- REPEAT, 3, number of full passes through the pattern (>=1).
- SW, max(1,$clog2(LEN)), width of step index.
- RW, max(1,$clog2(REPEAT)), width of repeat index.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  synchronous stop of a run; no done pulse.
- pattern_in  input  LEN  select pattern; bit 0 is played first; captured on accepted start.
- s  output  1  registered select to the 2:1 mux (0 selects i0, 1 selects i1).
- busy  output  1  high while in RUN.
- step_strobe  output  1  one-cycle pulse on the first cycle of every step.
- step_idx  output  SW  index of the current step, 0..LEN-1.
- rep_idx  output  RW  index of the current pass, 0..REPEAT-1.
- done  output  1  one-cycle pulse after the final step completes.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset (rst=1 at an edge), regardless of state: state=IDLE, s=0, busy=0, step_strobe=0, step_idx=0, rep_idx=0, done=0, pattern register=0, hold counter=0. rst has priority over abort and start.
- States: IDLE, RUN, DONE.
- IDLE:
  - s=0, busy=0.
  - On start=1 at edge k: capture pattern_in, go to RUN.
  - After edge k: s=pattern_in[0], busy=1, step_strobe=1, step_idx=0, rep_idx=0, hold counter=0.
- RUN: hold counter increments each cycle. When the counter reaches HOLD-1:
  - Counter resets to 0 and step_strobe pulses.
  - If step_idx<LEN-1: step_idx increments.
  - Else if rep_idx<REPEAT-1: step_idx=0 and rep_idx increments.
  - Else: go to DONE.
  - s always equals pattern_reg[step_idx] in the same cycle.
- Run length: busy is high for exactly LEN*HOLD*REPEAT consecutive cycles (150 at defaults).
- DONE: lasts exactly one cycle with done=1, busy=0, s=0, step_strobe=0. It then returns to IDLE unconditionally.
- start during RUN or DONE is ignored; pattern_in changes during RUN have no effect.
- abort=1 in RUN: next cycle state=IDLE, s=0, busy=0, indices=0, done stays 0. abort in IDLE or DONE has no effect.
- start and abort both high in IDLE: start wins.
- HOLD=1: s may change every cycle, and step_strobe stays high continuously during RUN.
- LEN=1 or REPEAT=1: the respective index stays at 0.
- Back-to-back runs: start is accepted on the first IDLE cycle after DONE, giving a minimum 2-cycle gap (DONE, IDLE) between runs.
- No combinational path from any input to any output.

Test Plan:
- Default params, pattern_in=5'b10110, start pulse at cycle 0:
  - s sequence 0,1,1,0,1, each held 10 cycles, repeated 3 times.
  - busy high 150 cycles; step_strobe pulses 15 times, 10 cycles apart.
  - done pulses once at cycle 151; s=0 afterwards.
- Index tracking: sample step_idx and rep_idx at every step_strobe. Required sequence is (0,0),(1,0)..(4,0),(0,1)..(4,2), with no repeats or skips.
- start held high throughout and pattern_in changed to 5'b01001 mid-run:
  - Current run is unaffected (still 0,1,1,0,1 pattern, 150 cycles).
  - New run starts on the IDLE cycle after DONE and plays 1,0,0,1,0.
- Abort at cycle 37 of a run: next cycle busy=0, s=0, step_idx=0, rep_idx=0; done never asserts. A later start produces a complete run.
- rst asserted at cycle 60 of a run, also with abort=1 and start=1 in the same cycle: all outputs return to their reset values next cycle and state is IDLE. After rst release, a start yields a normal 150-cycle run.
- Instance with HOLD=1, LEN=2, REPEAT=2, pattern_in=2'b10:
  - s toggles 0,1,0,1 on consecutive cycles.
  - busy high 4 cycles; step_strobe high all 4 cycles; done pulses on cycle 5.
